flex_mode_counter: RTL and testbench
====================================

FLEX_MODE_COUNTER -- requirements
Module: flex_mode_counter

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4, giving the counter width N (legal range 2..32).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port n_rst  input  1  one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clear  input  1  synchronous clear to 0, active-high.
REQ-005 SHALL have port load  input  1  synchronous parallel load of load_val, active-high.
REQ-006 SHALL have port load_val  input  N  value loaded when load=1.
REQ-007 SHALL have port count_enable  input  1  active-high step enable.
REQ-008 SHALL have port count_down  input  1  direction: 0 = increment, 1 = decrement.
REQ-009 SHALL have port mode  input  2  00 wrap-to-1 (legacy), 01 wrap-to-0, 10 saturate, 11 one-shot.
REQ-010 SHALL have port rollover_val  input  N  upper terminal value.
REQ-011 SHALL have port count_out  output  N  registered count.
REQ-012 SHALL have port rollover_flag  output  1  registered, high while count_out equals current terminal T.
REQ-013 SHALL have port wrap_pulse  output  1  registered, one-cycle pulse on each wrap event.
REQ-014 SHALL have port done  output  1  registered, one-shot completion flag.

Function
REQ-015 SHALL define lower bound L = 1 in mode 00, and L = 0 in modes 01, 10 and 11; in mode 00, rollover_val = 0 SHALL be treated as 1.
REQ-016 SHALL define terminal T = rollover_val when count_down = 0, and T = L when count_down = 1.
REQ-017 SHALL apply priority per edge: n_rst low > clear > load > count_enable > hold.
REQ-018 On clear, SHALL set count_out = 0, rollover_flag = 0, wrap_pulse = 0, done = 0.
REQ-019 On load, SHALL set count_out = load_val, rollover_flag = (load_val == T), wrap_pulse = 0, done = 0.
REQ-020 With count_enable = 1, count_down = 0 and count_out < rollover_val, SHALL increment by 1.
REQ-021 Up-counting with count_out >= rollover_val: modes 00/01 SHALL set next = L with wrap_pulse = 1; mode 10 SHALL set next = rollover_val; mode 11 SHALL set next = rollover_val and done = 1.
REQ-022 With count_enable = 1, count_down = 1 and count_out > L, SHALL decrement by 1, including when count_out > rollover_val.
REQ-023 Down-counting with count_out <= L: modes 00/01 SHALL set next = rollover_val with wrap_pulse = 1; mode 10 SHALL hold at L; mode 11 SHALL hold at L and done = 1.
REQ-024 In mode 11 with done = 1, SHALL ignore count_enable and hold count_out until clear or load.
REQ-025 SHALL deassert wrap_pulse on every cycle that is not a wrap event; it SHALL never stay high for 2 consecutive cycles unless 2 consecutive wraps occur.
REQ-026 rollover_flag SHALL be registered as (next count == T), using the T of the current cycle; when idle (no clear, load or enable), it SHALL hold its value.
REQ-027 SHALL perform all arithmetic modulo 2^N with no carry-out port; count_out SHALL never exceed 2^N-1.
REQ-028 A mode or rollover_val change SHALL take effect on the next enabled step, with no retroactive update of count_out.

Reset
REQ-029 On a clk edge with n_rst = 0, SHALL set count_out = 0, rollover_flag = 0, wrap_pulse = 0, done = 0, regardless of the other inputs.
REQ-030 SHALL have no asynchronous reset path; n_rst asserted mid-count SHALL take effect only at the next rising edge.

Verification
REQ-031 Mode 00, up, rollover_val = 5, enable held from 0: count_out 1,2,3,4,5,1,2; rollover_flag high only with 5; wrap_pulse high in the cycle count_out = 1 after 5.
REQ-032 Mode 01, down, rollover_val = 3, load 2 then enable: count_out 2,1,0,3,2; wrap_pulse with the 3; rollover_flag high with 0.
REQ-033 Mode 10, up, rollover_val = 15, load 14 then enable 4 cycles: count_out 15,15,15,15; wrap_pulse never asserts.
REQ-034 Mode 11, up, rollover_val = 4, from 0: count_out reaches 4; done = 1 next edge and held; 3 more enables leave 4; load 1 gives done = 0 and count_out = 1.
REQ-035 Simultaneous clear, load and count_enable at count_out = 7 -> count_out = 0. Then rollover_val lowered to 3 with count_out = 9, mode 01 up -> next count_out = 0 with wrap_pulse = 1.
REQ-036 n_rst low for 1 edge mid-count at count_out = 6 -> 0 after that edge, not before; all flags 0; counting resumes at 1 on the following enabled edge.

Source files
------------

// File: rtl/flex_mode_counter.sv
// Configurable up/down counter with four terminal behaviours: wrap-to-1, wrap-to-0,
// saturate and one-shot. All outputs are registered; reset is synchronous, active-low.
module flex_mode_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic [1:0]              mode,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse,
    output logic                    done
);

    typedef enum logic [1:0] {
        MODE_WRAP1   = 2'b00,
        MODE_WRAP0   = 2'b01,
        MODE_SAT     = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    localparam logic [NUM_CNT_BITS-1:0] ONE  = NUM_CNT_BITS'(1);
    localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;
    logic                    wrap_q, wrap_d;
    logic                    done_q, done_d;

    mode_e                   mode_sel;
    logic [NUM_CNT_BITS-1:0] lower_bound;
    logic [NUM_CNT_BITS-1:0] upper_bound;
    logic [NUM_CNT_BITS-1:0] terminal;
    logic                    step_allowed;

    // Legacy mode counts 1..R, so a zero rollover value degenerates to 1.
    always_comb begin
        mode_sel     = mode_e'(mode);
        lower_bound  = (mode_sel == MODE_WRAP1) ? ONE : ZERO;
        upper_bound  = ((mode_sel == MODE_WRAP1) && (rollover_val == ZERO)) ? ONE : rollover_val;
        terminal     = count_down ? lower_bound : upper_bound;
        step_allowed = count_enable && !((mode_sel == MODE_ONESHOT) && done_q);
    end

    always_comb begin
        count_d = count_q;
        flag_d  = flag_q;
        wrap_d  = 1'b0;
        done_d  = done_q;

        if (clear) begin
            count_d = ZERO;
            flag_d  = 1'b0;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_val;
            flag_d  = (load_val == terminal);
            done_d  = 1'b0;
        end else if (step_allowed) begin
            if (!count_down) begin
                if (count_q < upper_bound) begin
                    count_d = count_q + ONE;
                end else begin
                    unique case (mode_sel)
                        MODE_WRAP1, MODE_WRAP0: begin
                            count_d = lower_bound;
                            wrap_d  = 1'b1;
                        end
                        MODE_SAT: count_d = upper_bound;
                        MODE_ONESHOT: begin
                            count_d = upper_bound;
                            done_d  = 1'b1;
                        end
                        default: count_d = count_q;
                    endcase
                end
            end else begin
                // Values above the rollover limit still walk down one at a time.
                if (count_q > lower_bound) begin
                    count_d = count_q - ONE;
                end else begin
                    unique case (mode_sel)
                        MODE_WRAP1, MODE_WRAP0: begin
                            count_d = upper_bound;
                            wrap_d  = 1'b1;
                        end
                        MODE_SAT: count_d = lower_bound;
                        MODE_ONESHOT: begin
                            count_d = lower_bound;
                            done_d  = 1'b1;
                        end
                        default: count_d = count_q;
                    endcase
                end
            end
            flag_d = (count_d == terminal);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= ZERO;
            flag_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;
    assign wrap_pulse    = wrap_q;
    assign done          = done_q;

endmodule

// File: tb/tb_flex_mode_counter.sv
// Directed scenarios plus randomized traffic for flex_mode_counter, checked against
// an integer reference model of the counting rules.
module tb_flex_mode_counter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         clear = 1'b0;
    logic         load = 1'b0;
    logic [N-1:0] load_val = '0;
    logic         count_enable = 1'b0;
    logic         count_down = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [N-1:0] rollover_val = '0;
    logic [N-1:0] count_out;
    logic         rollover_flag;
    logic         wrap_pulse;
    logic         done;

    int checks = 0;
    int errors = 0;

    int m_count = 0;
    int m_flag = 0;
    int m_wrap = 0;
    int m_done = 0;

    flex_mode_counter #(.NUM_CNT_BITS(N)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .count_down   (count_down),
        .mode         (mode),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .wrap_pulse   (wrap_pulse),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: one edge of the counting rules, in plain integer arithmetic.
    task automatic modelEdge(input int rst_n, input int clr, input int ld, input int ldv,
                             input int en, input int dn, input int md, input int rv);
        int modulus = 1 << N;
        int lo = (md == 0) ? 1 : 0;
        int hi = (md == 0 && rv == 0) ? 1 : rv;
        int term = dn ? lo : hi;
        m_wrap = 0;
        if (!rst_n || clr) begin
            m_count = 0; m_flag = 0; m_done = 0;
        end else if (ld) begin
            m_count = ldv; m_flag = (ldv == term); m_done = 0;
        end else if (en && !(md == 3 && m_done)) begin
            if (!dn) begin
                if (m_count < hi) m_count = (m_count + 1) % modulus;
                else begin
                    m_count = (md <= 1) ? lo : hi;
                    if (md <= 1) m_wrap = 1;
                    if (md == 3) m_done = 1;
                end
            end else begin
                if (m_count > lo) m_count = m_count - 1;
                else begin
                    m_count = (md <= 1) ? hi : lo;
                    if (md <= 1) m_wrap = 1;
                    if (md == 3) m_done = 1;
                end
            end
            m_flag = (m_count == term);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".count"}, 32'(count_out), 32'(m_count));
        checkValue({tag, ".flag"},  32'(rollover_flag), 32'(m_flag));
        checkValue({tag, ".wrap"},  32'(wrap_pulse), 32'(m_wrap));
        checkValue({tag, ".done"},  32'(done), 32'(m_done));
    endtask

    task automatic applyStimulus(input string tag, input int rst_n, input int clr, input int ld,
                                 input int ldv, input int en, input int dn, input int md,
                                 input int rv);
        n_rst = rst_n[0]; clear = clr[0]; load = ld[0]; load_val = N'(ldv);
        count_enable = en[0]; count_down = dn[0]; mode = 2'(md); rollover_val = N'(rv);
        @(posedge clk);
        modelEdge(rst_n, clr, ld, ldv, en, dn, md, rv);
        #1;
        checkOutput(tag);
    endtask

    initial begin : main
        int exp031[7] = '{1, 2, 3, 4, 5, 1, 2};
        int exp032[4] = '{1, 0, 3, 2};

        applyStimulus("reset", 0, 1, 1, 9, 1, 0, 0, 5);
        checkValue("reset.count_const", 32'(count_out), 0);

        // Legacy wrap-to-1 counting up from 0 with limit 5.
        for (int i = 0; i < 7; i++) begin
            applyStimulus("m00_up", 1, 0, 0, 0, 1, 0, 0, 5);
            checkValue("m00_up.count_const", 32'(count_out), 32'(exp031[i]));
            checkValue("m00_up.wrap_const", 32'(wrap_pulse), (i == 5) ? 1 : 0);
            checkValue("m00_up.flag_const", 32'(rollover_flag), (exp031[i] == 5) ? 1 : 0);
        end

        applyStimulus("m01_load", 1, 0, 1, 2, 0, 1, 1, 3);
        checkValue("m01_load.count_const", 32'(count_out), 2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("m01_down", 1, 0, 0, 0, 1, 1, 1, 3);
            checkValue("m01_down.count_const", 32'(count_out), 32'(exp032[i]));
            checkValue("m01_down.wrap_const", 32'(wrap_pulse), (i == 2) ? 1 : 0);
            checkValue("m01_down.flag_const", 32'(rollover_flag), (i == 1) ? 1 : 0);
        end

        applyStimulus("m10_load", 1, 0, 1, 14, 0, 0, 2, 15);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("m10_sat", 1, 0, 0, 0, 1, 0, 2, 15);
            checkValue("m10_sat.count_const", 32'(count_out), 15);
            checkValue("m10_sat.wrap_const", 32'(wrap_pulse), 0);
        end

        applyStimulus("m11_clear", 1, 1, 0, 0, 0, 0, 3, 4);
        for (int i = 0; i < 4; i++) applyStimulus("m11_run", 1, 0, 0, 0, 1, 0, 3, 4);
        checkValue("m11_reach.count_const", 32'(count_out), 4);
        checkValue("m11_reach.done_const", 32'(done), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("m11_hold", 1, 0, 0, 0, 1, 0, 3, 4);
            checkValue("m11_hold.count_const", 32'(count_out), 4);
            checkValue("m11_hold.done_const", 32'(done), 1);
        end
        applyStimulus("m11_reload", 1, 0, 1, 1, 1, 0, 3, 4);
        checkValue("m11_reload.count_const", 32'(count_out), 1);
        checkValue("m11_reload.done_const", 32'(done), 0);

        applyStimulus("prio_load7", 1, 0, 1, 7, 0, 0, 1, 15);
        applyStimulus("prio_all", 1, 1, 1, 5, 1, 0, 1, 15);
        checkValue("prio_all.count_const", 32'(count_out), 0);
        applyStimulus("shrink_load9", 1, 0, 1, 9, 0, 0, 1, 15);
        applyStimulus("shrink_step", 1, 0, 0, 0, 1, 0, 1, 3);
        checkValue("shrink_step.count_const", 32'(count_out), 0);
        checkValue("shrink_step.wrap_const", 32'(wrap_pulse), 1);

        applyStimulus("rst_clear", 1, 1, 0, 0, 0, 0, 1, 15);
        for (int i = 0; i < 6; i++) applyStimulus("rst_run", 1, 0, 0, 0, 1, 0, 1, 15);
        n_rst = 1'b0;
        #2;
        checkValue("rst_before_edge.count_const", 32'(count_out), 6);
        applyStimulus("rst_mid", 0, 0, 0, 0, 1, 0, 1, 15);
        checkValue("rst_mid.count_const", 32'(count_out), 0);
        applyStimulus("rst_resume", 1, 0, 0, 0, 1, 0, 1, 15);
        checkValue("rst_resume.count_const", 32'(count_out), 1);

        // Randomized traffic; rare reset/clear, occasional load, mostly enabled steps.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random",
                          ($urandom_range(39) == 0) ? 0 : 1,
                          ($urandom_range(24) == 0) ? 1 : 0,
                          ($urandom_range(9) == 0) ? 1 : 0,
                          int'($urandom_range((1 << N) - 1)),
                          ($urandom_range(3) != 0) ? 1 : 0,
                          int'($urandom_range(1)),
                          int'($urandom_range(3)),
                          int'($urandom_range((1 << N) - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
